// File: rtl/hours_units_counter_pkg.sv
// Shared definitions for the digital clock hours digits: the set FSM encoding,
// the digit limits, and the wrap test used by the hours-units step.
package hours_units_counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } set_state_e;

    localparam logic [3:0] UNITS_MAX          = 4'd9;
    localparam logic [3:0] UNITS_MAX_AT_TENS2 = 4'd3;
    localparam logic [1:0] TENS_WRAP          = 2'd2;
    localparam int         CNT_W              = 8;

    function automatic logic [3:0] units_limit(input logic [1:0] tens);
        return (tens == TENS_WRAP) ? UNITS_MAX_AT_TENS2 : UNITS_MAX;
    endfunction

    // A >= compare rather than == so a stale digit above the limit is clamped.
    function automatic logic digit_wraps(input logic [3:0] units, input logic [1:0] tens);
        return units >= units_limit(tens);
    endfunction

endpackage

// File: rtl/hours_units_counter_slt.sv
// Select-button edge detect plus hold/auto-repeat sequencer for set-time stepping.
//
//   state  | meaning
//   IDLE   | waiting for a select rising edge in set mode
//   HOLD   | first step taken, counting down the hold delay
//   REPEAT | auto-repeating, one step each time the counter expires
module slt_autorepeat
    import hours_units_counter_pkg::*;
#(
    parameter int HOLD_DLY = 8,
    parameter int RPT_DIV  = 4
) (
    input  logic clkmain,
    input  logic clear,
    input  logic set_time,
    input  logic slt,
    output logic step_req,
    output logic set_busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_DLY - 1);
    localparam logic [CNT_W-1:0] RPT_LOAD  = CNT_W'(RPT_DIV - 1);

    set_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             slt_q, slt_d;
    logic             busy_q, busy_d;
    logic             rise;

    assign rise = slt & ~slt_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_req = 1'b0;
        slt_d    = slt;
        if (!set_time) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        step_req = 1'b1;
                        cnt_d    = HOLD_LOAD;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (!slt) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        cnt_d   = RPT_LOAD;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                REPEAT: begin
                    if (!slt) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        step_req = 1'b1;
                        cnt_d    = RPT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clkmain or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clkmain or posedge clear) begin
        if (clear) begin
            cnt_q  <= '0;
            slt_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            slt_q  <= slt_d;
            busy_q <= busy_d;
        end
    end

    assign set_busy = busy_q;

endmodule

// File: rtl/hours_units_counter.sv
// Hours-units BCD digit: steps on the minutes carry in run mode or on select in set
// mode, and emits a registered carry to the hours-tens counter on a run-mode wrap.
module hours_units_counter
    import hours_units_counter_pkg::*;
#(
    parameter int HOLD_DLY = 8,
    parameter int RPT_DIV  = 4
) (
    input  logic       clkmain,
    input  logic       clear,
    input  logic       tick_in,
    input  logic       set_time,
    input  logic       slt,
    input  logic [1:0] tens_in,
    output logic [3:0] units,
    output logic       carry_out,
    output logic       set_busy
);

    logic [3:0] units_q, units_d;
    logic       carry_q, carry_d;
    logic       step_req;
    logic       step_run;
    logic       step_now;
    logic       wrap;

    slt_autorepeat #(
        .HOLD_DLY (HOLD_DLY),
        .RPT_DIV  (RPT_DIV)
    ) u_slt (
        .clkmain  (clkmain),
        .clear    (clear),
        .set_time (set_time),
        .slt      (slt),
        .step_req (step_req),
        .set_busy (set_busy)
    );

    // Set-mode steps never carry: the tens digit is adjusted on its own.
    always_comb begin
        step_run = tick_in & ~set_time;
        step_now = step_run | step_req;
        wrap     = digit_wraps(units_q, tens_in);
        units_d  = units_q;
        if (step_now) begin
            units_d = wrap ? 4'd0 : units_q + 4'd1;
        end
        carry_d = step_run & wrap;
    end

    always_ff @(posedge clkmain or posedge clear) begin
        if (clear) begin
            units_q <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            units_q <= units_d;
            carry_q <= carry_d;
        end
    end

    assign units     = units_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_hours_units_counter.sv
// Directed-vector scoreboard bench for the hours-units digit stage.
module tb_hours_units_counter;

    logic       clkmain  = 1'b0;
    logic       clear    = 1'b0;
    logic       tick_in  = 1'b0;
    logic       set_time = 1'b0;
    logic       slt      = 1'b0;
    logic [1:0] tens_in  = 2'd0;
    logic [3:0] units;
    logic       carry_out;
    logic       set_busy;

    int checks   = 0;
    int failures = 0;
    int vec_id   = 0;

    typedef struct {
        int id;
        int u;
        int c;
        int b;
    } exp_t;

    exp_t exp_q[$];

    hours_units_counter #(
        .HOLD_DLY (8),
        .RPT_DIV  (4)
    ) dut (
        .clkmain   (clkmain),
        .clear     (clear),
        .tick_in   (tick_in),
        .set_time  (set_time),
        .slt       (slt),
        .tens_in   (tens_in),
        .units     (units),
        .carry_out (carry_out),
        .set_busy  (set_busy)
    );

    always #5 clkmain = ~clkmain;

    task automatic check(input string name, input int id, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, id, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic vec(input int tk, input int st, input int sl, input int tn,
                       input int eu, input int ec, input int eb);
        exp_t e;
        @(negedge clkmain);
        tick_in  = (tk != 0);
        set_time = (st != 0);
        slt      = (sl != 0);
        tens_in  = 2'(tn);
        e.id = vec_id;
        e.u  = eu;
        e.c  = ec;
        e.b  = eb;
        exp_q.push_back(e);
        vec_id++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clkmain);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("units", e.id, int'(units), e.u);
                check("carry_out", e.id, int'(carry_out), e.c);
                check("set_busy", e.id, int'(set_busy), e.b);
            end
        end
    end

    initial begin : driver
        #1 clear = 1'b1;
        #1;
        check("reset_units", -1, int'(units), 0);
        check("reset_carry", -1, int'(carry_out), 0);
        check("reset_busy", -1, int'(set_busy), 0);
        #1 clear = 1'b0;

        // Run mode, tens=0: full decade with carry after the tenth tick.
        for (int i = 1; i <= 10; i++) vec(1, 0, 0, 0, i % 10, (i == 10) ? 1 : 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0);

        // Count to 6, then an asynchronous clear between edges.
        for (int i = 1; i <= 6; i++) vec(1, 0, 0, 0, i, 0, 0);
        @(negedge clkmain);
        tick_in = 1'b0;
        clear   = 1'b1;
        #1;
        check("clear_units", -2, int'(units), 0);
        check("clear_carry", -2, int'(carry_out), 0);
        check("clear_busy", -2, int'(set_busy), 0);
        #1 clear = 1'b0;
        vec(1, 0, 0, 0, 1, 0, 0);

        // tens=2: 23 -> 00 rollover.
        vec(1, 0, 0, 2, 2, 0, 0);
        vec(1, 0, 0, 2, 3, 0, 0);
        vec(1, 0, 0, 2, 0, 1, 0);
        vec(0, 0, 0, 2, 0, 0, 0);

        // Stale 7 with tens switched to 2 clamps and carries; back-to-back tick.
        for (int i = 1; i <= 7; i++) vec(1, 0, 0, 0, i, 0, 0);
        vec(1, 0, 0, 2, 0, 1, 0);
        vec(1, 0, 0, 2, 1, 0, 0);

        // Set mode ignores tick_in.
        for (int i = 0; i < 3; i++) vec(1, 1, 0, 0, 1, 0, 0);

        // Up to 8 in run mode.
        for (int i = 2; i <= 8; i++) vec(1, 0, 0, 0, i, 0, 0);

        // Hold select for 20 cycles (set_time rises with the press): 8->9, repeat 0, 1.
        for (int j = 0; j < 20; j++)
            vec((j == 5) ? 1 : 0, 1, 1, 0, (j < 12) ? 9 : ((j < 16) ? 0 : 1), 0, 1);
        vec(0, 1, 0, 0, 1, 0, 0);

        // Up to 7, then press with tens=2: clamp wrap without carry.
        for (int i = 2; i <= 7; i++) vec(1, 0, 0, 0, i, 0, 0);
        for (int j = 0; j < 4; j++) vec(0, 1, 1, 2, 0, 0, 1);
        vec(0, 0, 1, 2, 0, 0, 0);
        vec(0, 0, 1, 2, 0, 0, 0);
        // Re-entering set mode with select still held is not a new press.
        for (int j = 0; j < 4; j++) vec(0, 1, 1, 2, 0, 0, 0);
        vec(0, 1, 0, 2, 0, 0, 0);
        vec(0, 1, 1, 2, 1, 0, 1);
        vec(0, 1, 0, 2, 1, 0, 0);
        vec(1, 0, 0, 2, 2, 0, 0);
        vec(0, 0, 0, 2, 2, 0, 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clkmain);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
